// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 frame-buffer controller: register map,
// command-word packing and controller state encoding.
package max7219_pkg;

  localparam logic [3:0] DIGIT0     = 4'h1;
  localparam logic [3:0] DIGIT1     = 4'h2;
  localparam logic [3:0] DIGIT2     = 4'h3;
  localparam logic [3:0] DIGIT3     = 4'h4;
  localparam logic [3:0] DIGIT4     = 4'h5;
  localparam logic [3:0] DIGIT5     = 4'h6;
  localparam logic [3:0] DIGIT6     = 4'h7;
  localparam logic [3:0] DIGIT7     = 4'h8;
  localparam logic [3:0] DECODE     = 4'h9;
  localparam logic [3:0] INTENSITY  = 4'hA;
  localparam logic [3:0] SCAN_LIMIT = 4'hB;
  localparam logic [3:0] SHUTDOWN   = 4'hC;
  localparam logic [3:0] TEST       = 4'hF;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_INIT_ISSUE,
    ST_SCAN,
    ST_HANDSHAKE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_t;

  function automatic logic [15:0] make_word(input logic [3:0] addr, input logic [7:0] value);
    return {4'h0, addr, value};
  endfunction

endpackage

// File: rtl/max7219_fb_mem.sv
// 8x8 frame buffer with one dirty bit per row; a write in the same cycle as
// the issue-clear of that row keeps the row dirty.
module max7219_fb_mem (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
  input  logic [2:0] rd_row,
  output logic [7:0] rd_data,
  input  logic       clr_en,
  output logic [7:0] dirty
);

  logic [7:0] fb [8];
  logic [7:0] set_mask;
  logic [7:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (wr_en)  set_mask[wr_row] = 1'b1;
    if (clr_en) clr_mask[rd_row] = 1'b1;
  end

  assign rd_data = fb[rd_row];

  // NOTE: the pixel array is reset on purpose: after reset every row is dirty
  // and must go out as a blank row, so the stored data has to be known zero.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int i = 0; i < 8; i++) fb[i] <= '0;
      dirty <= '1;
    end else begin
      if (wr_en) fb[wr_row] <= wr_data;
      dirty <= (dirty & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: rtl/max7219_fb_ctrl.sv
// MAX7219 frame-buffer controller: power-up wait, register init sequence,
// then one command word per changed row or intensity update.
module max7219_fb_ctrl
  import max7219_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES = 1000,
  parameter logic [3:0]  INIT_INTENSITY = 4'h8
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Fb_We,
  input  logic [2:0]  i_Fb_Row,
  input  logic [7:0]  i_Fb_Data,
  input  logic        i_Intensity_Set,
  input  logic [3:0]  i_Intensity,
  output logic        o_Ready,
  output logic        o_Data_Ready,
  output logic [15:0] o_Data,
  input  logic        i_Busy
);

  localparam logic [19:0] PWR_LAST = 20'(POWERUP_CYCLES - 1);

  state_t      state;
  logic [19:0] pwr_cnt;
  logic [2:0]  init_idx;
  logic [2:0]  row_ptr;
  logic [3:0]  intensity;
  logic        int_pending;
  logic [7:0]  rd_data;
  logic [7:0]  dirty;
  logic        issue_row;
  logic [15:0] init_word;

  assign issue_row = (state == ST_SCAN) && !int_pending && dirty[row_ptr];

  max7219_fb_mem u_mem (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .wr_en   (i_Fb_We),
    .wr_row  (i_Fb_Row),
    .wr_data (i_Fb_Data),
    .rd_row  (row_ptr),
    .rd_data (rd_data),
    .clr_en  (issue_row),
    .dirty   (dirty)
  );

  always_comb begin
    init_word = make_word(SHUTDOWN, 8'h01);
    case (init_idx)
      3'd0:    init_word = make_word(TEST, 8'h00);
      3'd1:    init_word = make_word(SCAN_LIMIT, 8'h07);
      3'd2:    init_word = make_word(DECODE, 8'h00);
      3'd3:    init_word = make_word(INTENSITY, {4'h0, intensity});
      default: init_word = make_word(SHUTDOWN, 8'h01);
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state        <= ST_POWERUP;
      pwr_cnt      <= '0;
      init_idx     <= '0;
      row_ptr      <= '0;
      intensity    <= INIT_INTENSITY;
      int_pending  <= 1'b0;
      o_Ready      <= 1'b0;
      o_Data_Ready <= 1'b0;
      o_Data       <= '0;
    end else begin
      o_Data_Ready <= 1'b0;
      case (state)
        ST_POWERUP: begin
          if (pwr_cnt == PWR_LAST) begin
            init_idx <= '0;
            state    <= ST_INIT_ISSUE;
          end else begin
            pwr_cnt <= pwr_cnt + 20'd1;
          end
        end
        ST_INIT_ISSUE: begin
          o_Data <= init_word;
          state  <= ST_HANDSHAKE;
        end
        ST_SCAN: begin
          if (int_pending) begin
            o_Data      <= make_word(INTENSITY, {4'h0, intensity});
            int_pending <= 1'b0;
            state       <= ST_HANDSHAKE;
          end else begin
            if (dirty[row_ptr]) begin
              o_Data <= make_word(DIGIT0 + {1'b0, row_ptr}, rd_data);
              state  <= ST_HANDSHAKE;
            end
            row_ptr <= row_ptr + 3'd1;
          end
        end
        ST_HANDSHAKE: begin
          if (!i_Busy) begin
            o_Data_Ready <= 1'b1;
            state        <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (i_Busy) state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (!i_Busy) begin
            if (o_Ready) begin
              state <= ST_SCAN;
            end else if (init_idx == 3'd4) begin
              o_Ready <= 1'b1;
              state   <= ST_SCAN;
            end else begin
              init_idx <= init_idx + 3'd1;
              state    <= ST_INIT_ISSUE;
            end
          end
        end
        default: state <= ST_POWERUP;
      endcase
      // NOTE: non-blocking assignments take the last write in the block, so a
      // new request here overrides the pending-clear of an issue this cycle.
      if (i_Intensity_Set) begin
        intensity   <= i_Intensity;
        int_pending <= 1'b1;
      end
    end
  end

endmodule
